// File: rtl/park_gate_ctrl.sv
// Round-robin gate arbiter and barrier sequencer feeding the lot's car_in/car_out count path.
// Optional build macro EXIT_PRIORITY_EN: eligible exit lanes win over entry lanes, each group with its own pointer.
module park_gate_ctrl #(
  parameter int N_IN         = 2,
  parameter int N_OUT        = 2,
  parameter int CAPACITY     = 12,
  parameter int OPEN_TIMEOUT = 16,
  parameter int CLOSE_CYC    = 4,
  localparam int N           = N_IN + N_OUT,
  localparam int GW          = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  entry_req,
  input  logic [N_OUT-1:0] exit_req,
  input  logic [N-1:0]     pass_det,
  input  logic [3:0]       free_spot,
  input  logic             parking_full,
  output logic [N-1:0]     gate_open,
  output logic [GW-1:0]    grant_id,
  output logic             car_in,
  output logic             car_out,
  output logic [N_IN-1:0]  entry_deny,
  output logic             timeout,
  output logic             busy
);

  localparam int TMAX = (OPEN_TIMEOUT > CLOSE_CYC) ? OPEN_TIMEOUT : CLOSE_CYC;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [1:0] {IDLE, OPEN, COMMIT, CLOSE} state_t;

  // Handshake: a lane request is a level; it is accepted when its barrier opens
  // (grant), and the passage completes only when that lane's pass_det is seen in OPEN.
  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic           timeout_q, timeout_d;
  logic [N-1:0]   elig;
  logic           pick_valid;
  logic [GW-1:0]  pick_id;
  logic           grant_fire;
  int             a_idx;

  always_comb begin
    elig = {exit_req & {N_OUT{free_spot < 4'(CAPACITY)}},
            entry_req & {N_IN{~parking_full}}};
  end

`ifdef EXIT_PRIORITY_EN
  logic [GW-1:0] ptr_in_q, ptr_in_d, ptr_out_q, ptr_out_d;
  logic          pick_exit;

  always_comb begin
    pick_valid = 1'b0;
    pick_exit  = 1'b0;
    pick_id    = '0;
    ptr_in_d   = ptr_in_q;
    ptr_out_d  = ptr_out_q;
    a_idx      = 0;
    for (int k = 0; k < N_OUT; k++) begin
      a_idx = int'(ptr_out_q) + k;
      if (a_idx >= N_OUT) a_idx = a_idx - N_OUT;
      if (!pick_valid && elig[GW'(N_IN + a_idx)]) begin
        pick_valid = 1'b1;
        pick_exit  = 1'b1;
        pick_id    = GW'(N_IN + a_idx);
        ptr_out_d  = (a_idx + 1 >= N_OUT) ? '0 : GW'(a_idx + 1);
      end
    end
    for (int k = 0; k < N_IN; k++) begin
      a_idx = int'(ptr_in_q) + k;
      if (a_idx >= N_IN) a_idx = a_idx - N_IN;
      if (!pick_valid && elig[GW'(a_idx)]) begin
        pick_valid = 1'b1;
        pick_id    = GW'(a_idx);
        ptr_in_d   = (a_idx + 1 >= N_IN) ? '0 : GW'(a_idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_in_q  <= '0;
      ptr_out_q <= '0;
    end else if (grant_fire) begin
      if (pick_exit) ptr_out_q <= ptr_out_d;
      else           ptr_in_q  <= ptr_in_d;
    end
  end
`else
  logic [GW-1:0] ptr_q, ptr_d;

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    ptr_d      = ptr_q;
    a_idx      = 0;
    for (int k = 0; k < N; k++) begin
      a_idx = int'(ptr_q) + k;
      if (a_idx >= N) a_idx = a_idx - N;
      if (!pick_valid && elig[GW'(a_idx)]) begin
        pick_valid = 1'b1;
        pick_id    = GW'(a_idx);
        ptr_d      = (a_idx + 1 >= N) ? '0 : GW'(a_idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)            ptr_q <= '0;
    else if (grant_fire) ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    grant_d    = grant_q;
    timeout_d  = 1'b0;
    grant_fire = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pick_valid) begin
          grant_fire = 1'b1;
          grant_d    = pick_id;
          state_d    = OPEN;
        end
      end
      OPEN: begin
        // A pass seen on the expiry cycle still counts as a passage.
        if (pass_det[grant_q]) begin
          state_d = COMMIT;
          timer_d = '0;
        end else if (timer_q == TW'(OPEN_TIMEOUT - 1)) begin
          state_d   = CLOSE;
          timer_d   = '0;
          timeout_d = 1'b1;
        end
      end
      COMMIT: begin
        state_d = CLOSE;
        timer_d = '0;
      end
      CLOSE: begin
        if (timer_q == TW'(CLOSE_CYC - 1)) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      grant_q    <= '0;
      timeout_q  <= 1'b0;
      entry_deny <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      grant_q    <= grant_d;
      timeout_q  <= timeout_d;
      entry_deny <= entry_req & {N_IN{parking_full}};
    end
  end

  always_comb begin
    gate_open = '0;
    if (state_q == OPEN || state_q == COMMIT)
      gate_open = {{(N-1){1'b0}}, 1'b1} << grant_q;
    grant_id = grant_q;
    car_in   = (state_q == COMMIT) && (int'(grant_q) < N_IN);
    car_out  = (state_q == COMMIT) && (int'(grant_q) >= N_IN);
    timeout  = timeout_q;
    busy     = (state_q != IDLE);
  end

endmodule
